// File: rtl/mul_shift_add_pkg.sv
// Shared constants for the shift-add multiplier: control-state encodings (also decoded
// by the divider's control unit), the default operand width and an operand magnitude helper.
package mul_shift_add_pkg;

    localparam int DEFAULT_WIDTH = 16;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = IDLE,
        S_RUN  = RUN,
        S_DONE = DONE
    } state_t;

    // The most negative value maps to itself, which reads correctly as an unsigned magnitude.
    function automatic logic [DEFAULT_WIDTH-1:0] magnitude16(input logic [DEFAULT_WIDTH-1:0] v);
        return v[DEFAULT_WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mul_shift_add_if.sv
// Operand/result bundle between the control unit (master) and the multiplier (slave).
interface mul_shift_add_if
    import mul_shift_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic [WIDTH-1:0]         a;
    logic [WIDTH-1:0]         b;
    logic                     start;
    logic [2*WIDTH-1:0]       p;
    logic                     busy;
    logic                     ready;
    logic [$clog2(WIDTH)-1:0] count;

    modport master (output a, b, start, input p, busy, ready, count);
    modport slave  (input a, b, start, output p, busy, ready, count);
endinterface

// File: rtl/mul_shift_add_step.sv
// One radix-2 partial-product step: add the multiplicand into the high half when the
// current multiplier bit is set, keeping the carry as an extra bit.
module mul_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] hi,
    input  logic             lsb,
    input  logic [WIDTH-1:0] mcand,
    output logic [WIDTH:0]   sum
);
    assign sum = {1'b0, hi} + (lsb ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
endmodule

// File: rtl/mul_shift_add.sv
// Sequential radix-2 shift-add multiplier, one partial product per clock, start/busy/ready handshake.
// Define MUL_SIGNED_EN for two's-complement operands (sign-magnitude with final negation).
//
// state  | meaning
// IDLE   | after reset, no product available
// RUN    | iterating, p holds partial state
// DONE   | product valid on p, held until next start
module mul_shift_add
    import mul_shift_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic             clk,
    input logic             clrn,
    mul_shift_add_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   mcand, hi, lo;
    logic [CW-1:0]      count;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] shifted, prod_nxt;
    logic               last;

    mul_step #(.WIDTH(WIDTH)) u_step (
        .hi   (hi),
        .lsb  (lo[0]),
        .mcand(mcand),
        .sum  (sum)
    );

    assign last    = (count == CW'(WIDTH - 1));
    assign shifted = {sum, lo[WIDTH-1:1]};

`ifdef MUL_SIGNED_EN
    logic neg;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    assign prod_nxt = (last && neg) ? (~shifted + 1'b1) : shifted;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            neg <= 1'b0;
        end else if (bus.start) begin
            neg <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
        end
    end
`else
    assign prod_nxt = shifted;
`endif

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // start wins from any state, including mid-run; a restart simply reloads.
    always_comb begin
        state_nxt = state;
        if (bus.start) begin
            state_nxt = S_RUN;
        end else if (state == S_RUN && last) begin
            state_nxt = S_DONE;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            count <= '0;
        end else if (bus.start) begin
`ifdef MUL_SIGNED_EN
            mcand <= mag(bus.a);
            lo    <= mag(bus.b);
`else
            mcand <= bus.a;
            lo    <= bus.b;
`endif
            hi    <= '0;
            count <= '0;
        end else if (state == S_RUN) begin
            hi    <= prod_nxt[2*WIDTH-1:WIDTH];
            lo    <= prod_nxt[WIDTH-1:0];
            count <= count + 1'b1;
        end
    end

    assign bus.p     = {hi, lo};
    assign bus.busy  = (state == S_RUN);
    assign bus.ready = (state == S_DONE);
    assign bus.count = count;

endmodule

// File: tb/tb_mul_shift_add.sv
// Directed-vector bench for mul_shift_add with an expected-product scoreboard drained by a
// monitor on every rising ready.
module tb_mul_shift_add;
    import mul_shift_add_pkg::*;

    localparam int W = 16;

    typedef struct {
        logic [2*W-1:0] p;
        int             load;
    } exp_t;

    logic clk = 1'b0;
    logic clrn;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    logic ready_q = 1'b0;

    mul_shift_add_if #(.WIDTH(W)) bus ();

    mul_shift_add #(.WIDTH(W)) dut (
        .clk (clk),
        .clrn(clrn),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: each rising ready must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.ready && !ready_q) begin
            if (sb.size() == 0) begin
                check("spurious_ready", {32'd0, bus.p}, 64'hDEAD);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("product", {32'd0, bus.p}, {32'd0, e.p});
                check("latency", 64'(cyc - e.load), 64'd16);
                check("busy_at_ready", {63'd0, bus.busy}, 64'd0);
                check("count_at_ready", {60'd0, bus.count}, 64'd0);
            end
        end
        ready_q <= bus.ready;
    end

    // Caller is at a negedge; returns just after the load edge.
    task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] exp);
        exp_t e;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        e.p       = exp;
        e.load    = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = '1;
        bus.b     = '1;
    endtask

    task automatic wait_ready();
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.ready) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_vec(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] exp);
        @(negedge clk);
        do_start(a, b, exp);
        wait_ready();
    endtask

    initial begin
        clrn      = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_ready", {63'd0, bus.ready}, 64'd0);
        check("rst_p", {32'd0, bus.p}, 64'd0);
        check("rst_count", {60'd0, bus.count}, 64'd0);
        clrn = 1'b1;

        // Reset in the middle of a run.
        @(negedge clk);
        do_start(16'h1234, 16'h5678, 32'h06260060);
        repeat (5) @(negedge clk);
        clrn = 1'b0;
        sb.delete();
        #1;
        check("midrst_busy", {63'd0, bus.busy}, 64'd0);
        check("midrst_ready", {63'd0, bus.ready}, 64'd0);
        check("midrst_p", {32'd0, bus.p}, 64'd0);
        check("midrst_count", {60'd0, bus.count}, 64'd0);
        @(negedge clk);
        clrn = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_ready", {63'd0, bus.ready}, 64'd0);
        check("post_rst_busy", {63'd0, bus.busy}, 64'd0);

        // Basic product, then hold.
        run_vec(16'h1234, 16'h5678, 32'h06260060);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_ready", {63'd0, bus.ready}, 64'd1);
            check("hold_p", {32'd0, bus.p}, 64'h06260060);
        end
        do_start(16'd2, 16'd2, 32'd4);
        check("restart_ready_drop", {63'd0, bus.ready}, 64'd0);
        check("restart_busy", {63'd0, bus.busy}, 64'd1);
        wait_ready();

`ifdef MUL_SIGNED_EN
        run_vec(16'hFFFF, 16'hFFFF, 32'h00000001);
        run_vec(16'h0000, 16'hABCD, 32'h00000000);
        run_vec(16'h0001, 16'h8000, 32'hFFFF8000);
        run_vec(16'hFFFD, 16'h0005, 32'hFFFFFFF1);
        run_vec(16'h8000, 16'h8000, 32'h40000000);
        run_vec(16'h8000, 16'h0001, 32'hFFFF8000);
`else
        run_vec(16'hFFFF, 16'hFFFF, 32'hFFFE0001);
        run_vec(16'h0000, 16'hABCD, 32'h00000000);
        run_vec(16'h0001, 16'h8000, 32'h00008000);
`endif

        // Abort at count 7 and restart with new operands; only the second result may appear.
        @(negedge clk);
        do_start(16'd3, 16'd5, 32'd15);
        begin
            bit hit = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (bus.count == 4'd7) begin
                    hit = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            check("reached_count7", {63'd0, hit}, 64'd1);
        end
        void'(sb.pop_back());
        do_start(16'd7, 16'd9, 32'h0000003F);
        wait_ready();

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
